cpu_io_bridge: RTL and testbench

Parametrised Z80 I/O-port front end for the V9958 core. It decodes a power-of-two block of I/O ports and filters the CPU strobes. Each accepted cycle becomes a single-cycle request carrying a port index. It stretches the CPU cycle with WAIT until the VDP core acknowledges, and it drives latched read data back onto the CPU bus. Sits between the Z80 bus pins and the VDP register/VRAM access logic, entirely in the `clk` domain.

---
 rtl/cpu_io_pkg.sv | 19 +
 rtl/io_pin_filter.sv | 48 ++++
 rtl/cpu_io_bridge.sv | 142 ++++++++++++++
 tb/tb_cpu_io_bridge.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the Z80 I/O-port front end of the V9958 core.
package cpu_io_pkg;

  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} io_state_t;

  localparam logic [7:0] RD_DEFAULT = 8'hFF;

  localparam int PORT_BITS_MIN    = 1;
  localparam int PORT_BITS_MAX    = 4;
  localparam int FILTER_DEPTH_MIN = 2;
  localparam int FILTER_DEPTH_MAX = 8;
  localparam int ACK_TIMEOUT_MIN  = 1;
  localparam int ACK_TIMEOUT_MAX  = 255;

  function automatic bit in_range(input int val, input int lo, input int hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/io_pin_filter.sv
// Two-flop synchroniser followed by a stability counter: dout follows din only
// after DEPTH consecutive identical synchronised samples.
module io_pin_filter #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic          sync1_q, sync2_q;
  logic          dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample equal to the current output restarts the run count.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (sync2_q != dout_q) begin
      if (cnt_q == LAST) begin
        dout_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/cpu_io_bridge.sv
// Z80 I/O-port decoder: filters CPU strobes, issues one request per cycle to the
// VDP core, stretches the CPU with WAIT until acknowledge and returns read data.
module cpu_io_bridge
  import cpu_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'h98,
  parameter int         PORT_BITS    = 2,
  parameter int         FILTER_DEPTH = 3,
  parameter int         WAIT_ENABLE  = 1,
  parameter int         ACK_TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           A,
  inout  wire  [7:0]           cd,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 iorq_n,
  input  logic                 m1_n,
  output logic                 cs_n,
  output logic                 wait_n,
  output logic                 CpuReq,
  output logic                 CpuWrt,
  output logic [PORT_BITS-1:0] CpuPort,
  output logic [7:0]           CpuDbo,
  input  logic [7:0]           CpuDbi,
  input  logic                 CpuAck,
  output logic                 CpuTimeout
);

  localparam bit CFG_OK = in_range(PORT_BITS, PORT_BITS_MIN, PORT_BITS_MAX)
                       && in_range(FILTER_DEPTH, FILTER_DEPTH_MIN, FILTER_DEPTH_MAX)
                       && in_range(ACK_TIMEOUT, ACK_TIMEOUT_MIN, ACK_TIMEOUT_MAX)
                       && in_range(WAIT_ENABLE, 0, 1);
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("cpu_io_bridge: parameter out of range");
    end
  endgenerate

  logic match, csr_raw, csw_raw, csr_f, csw_f;

  io_state_t            io_state_q, io_state_d;
  logic                 cpu_req_q, cpu_req_d;
  logic                 cpu_wrt_q, cpu_wrt_d;
  logic [PORT_BITS-1:0] cpu_port_q, cpu_port_d;
  logic [7:0]           cpu_dbo_q, cpu_dbo_d;
  logic                 cpu_timeout_q, cpu_timeout_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic [7:0]           cnt_q, cnt_d;

  // Interrupt-acknowledge cycles (m1_n low) also assert iorq_n and must not match.
  assign match   = (A[7:PORT_BITS] == BASE_ADDR[7:PORT_BITS]) && !iorq_n && m1_n;
  assign csr_raw = match && !rd_n;
  assign csw_raw = match && !wr_n;
  assign cs_n    = !match;

  io_pin_filter #(.DEPTH(FILTER_DEPTH)) u_filt_rd (
    .clk(clk), .reset_n(reset_n), .din(csr_raw), .dout(csr_f)
  );
  io_pin_filter #(.DEPTH(FILTER_DEPTH)) u_filt_wr (
    .clk(clk), .reset_n(reset_n), .din(csw_raw), .dout(csw_f)
  );

  always_comb begin
    io_state_d    = io_state_q;
    cpu_req_d     = 1'b0;
    cpu_timeout_d = 1'b0;
    cpu_wrt_d     = cpu_wrt_q;
    cpu_port_d    = cpu_port_q;
    cpu_dbo_d     = cpu_dbo_q;
    rd_data_d     = rd_data_q;
    cnt_d         = cnt_q;
    unique case (io_state_q)
      IDLE: begin
        if (csr_f != csw_f) begin
          cpu_port_d = A[PORT_BITS-1:0];
          cpu_dbo_d  = cd;
          cpu_wrt_d  = csw_f;
          io_state_d = REQ;
        end
      end
      REQ: begin
        cpu_req_d  = 1'b1;
        cnt_d      = 8'd0;
        io_state_d = ACK;
      end
      ACK: begin
        if (CpuAck) begin
          if (!cpu_wrt_q) rd_data_d = CpuDbi;
          io_state_d = HOLD;
        end else if (cnt_q == TO_LAST) begin
          rd_data_d     = RD_DEFAULT;
          cpu_timeout_d = 1'b1;
          io_state_d    = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        // Both filtered strobes must be seen released before the next cycle.
        if (!csr_f && !csw_f) io_state_d = IDLE;
      end
      default: io_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_state_q    <= IDLE;
      cpu_req_q     <= 1'b0;
      cpu_wrt_q     <= 1'b0;
      cpu_port_q    <= '0;
      cpu_dbo_q     <= 8'd0;
      cpu_timeout_q <= 1'b0;
      rd_data_q     <= RD_DEFAULT;
      cnt_q         <= 8'd0;
    end else begin
      io_state_q    <= io_state_d;
      cpu_req_q     <= cpu_req_d;
      cpu_wrt_q     <= cpu_wrt_d;
      cpu_port_q    <= cpu_port_d;
      cpu_dbo_q     <= cpu_dbo_d;
      cpu_timeout_q <= cpu_timeout_d;
      rd_data_q     <= rd_data_d;
      cnt_q         <= cnt_d;
    end
  end

  // WAIT uses the raw decode so it is low before the CPU's first wait sample.
  assign wait_n = !((WAIT_ENABLE != 0) && (csr_raw || csw_raw) && (io_state_q != HOLD) && reset_n);
  assign cd     = csr_raw ? rd_data_q : 8'bz;

  assign CpuReq     = cpu_req_q;
  assign CpuWrt     = cpu_wrt_q;
  assign CpuPort    = cpu_port_q;
  assign CpuDbo     = cpu_dbo_q;
  assign CpuTimeout = cpu_timeout_q;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed plus randomised bus cycles against two bridge instances (default
// decode at 8'h98, and BASE_ADDR=8'h88/PORT_BITS=3), checked by a cycle-level model.
module tb_cpu_io_bridge;
  import cpu_io_pkg::*;

  localparam int FD = 3;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] A;
  wire  [7:0] cd;
  logic       rd_n, wr_n, iorq_n, m1_n;
  logic [7:0] CpuDbi;
  logic       CpuAck;
  logic [7:0] tb_cd;
  logic       tb_cd_oe;

  logic       cs1_n, wait1_n, req1, wrt1, to1;
  logic [1:0] port1;
  logic [7:0] dbo1;
  logic       cs2_n, wait2_n, req2, wrt2, to2;
  logic [2:0] port2;
  logic [7:0] dbo2;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign cd = tb_cd_oe ? tb_cd : 8'bz;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pd
      pulldown (cd[gi]);
    end
  endgenerate

  cpu_io_bridge dut1 (
    .clk(clk), .reset_n(reset_n), .A(A), .cd(cd), .rd_n(rd_n), .wr_n(wr_n),
    .iorq_n(iorq_n), .m1_n(m1_n), .cs_n(cs1_n), .wait_n(wait1_n), .CpuReq(req1),
    .CpuWrt(wrt1), .CpuPort(port1), .CpuDbo(dbo1), .CpuDbi(CpuDbi), .CpuAck(CpuAck),
    .CpuTimeout(to1)
  );

  cpu_io_bridge #(.BASE_ADDR(8'h88), .PORT_BITS(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .A(A), .cd(cd), .rd_n(rd_n), .wr_n(wr_n),
    .iorq_n(iorq_n), .m1_n(m1_n), .cs_n(cs2_n), .wait_n(wait2_n), .CpuReq(req2),
    .CpuWrt(wrt2), .CpuPort(port2), .CpuDbo(dbo2), .CpuDbi(CpuDbi), .CpuAck(CpuAck),
    .CpuTimeout(to2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address is in the block when it differs from the base only in the low pb bits.
  function automatic bit decodes(input logic [7:0] addr, input logic [7:0] base, input int pb);
    return ((addr ^ base) >> pb) == 8'd0;
  endfunction

  // One CPU I/O cycle: strobe held for len clocks, ack ack_dly clocks after the
  // request (0 = never), then idle long enough for any timeout and release.
  task automatic run_cycle(input string name, input bit do_rd, input bit do_wr, input bit m1n,
                           input logic [7:0] addr, input logic [7:0] data, input logic [7:0] dbi,
                           input int len, input int ack_dly);
    bit         hit1, hit2, exp_req, done, act, rd_act;
    int         n1, n2, nto, req_it, to_it, ack_it;
    logic [2:0] port_obs;
    logic       wrt_obs;
    logic [7:0] dbo_obs, exp_rd;
    n1 = 0; n2 = 0; nto = 0; req_it = -1; to_it = -1; ack_it = -1; done = 1'b0;
    port_obs = '0; wrt_obs = 1'b0; dbo_obs = '0;
    hit1    = decodes(addr, 8'h98, 2) && m1n;
    hit2    = decodes(addr, 8'h88, 3) && m1n;
    exp_req = (hit1 || hit2) && (do_rd != do_wr) && (len >= FD);
    exp_rd  = (ack_dly > 0) ? dbi : RD_DEFAULT;
    A = addr; CpuDbi = dbi; tb_cd = data; tb_cd_oe = do_wr && !do_rd;
    for (int it = 0; it < len + 40; it++) begin
      @(posedge clk); #1;
      act    = (it < len);
      iorq_n = !act;
      rd_n   = !(act && do_rd);
      wr_n   = !(act && do_wr);
      m1_n   = act ? m1n : 1'b1;
      CpuAck = (req_it >= 0) && (ack_dly > 0) && (it == req_it + ack_dly);
      @(negedge clk);
      if (ack_it >= 0) done = 1'b1;
      if (req1) begin n1++; req_it = it; port_obs = {1'b0, port1}; wrt_obs = wrt1; dbo_obs = dbo1; end
      if (req2) begin n2++; req_it = it; port_obs = port2; wrt_obs = wrt2; dbo_obs = dbo2; end
      if (to1 || to2) begin nto++; to_it = it; done = 1'b1; end
      if (CpuAck) ack_it = it;
      chk({name, " wait_n"}, 32'(wait1_n & wait2_n),
          32'(!(act && (hit1 || hit2) && (do_rd || do_wr) && !done)));
      chk({name, " cs_n1"}, 32'(cs1_n), 32'(!(act && hit1)));
      chk({name, " cs_n2"}, 32'(cs2_n), 32'(!(act && hit2)));
      rd_act = act && do_rd && (hit1 || hit2);
      if (rd_act && done) chk({name, " cd_read"}, 32'(cd), 32'(exp_rd));
      else if (!rd_act && !tb_cd_oe) chk({name, " cd_hiz"}, 32'(cd), 32'h00);
    end
    CpuAck = 1'b0; tb_cd_oe = 1'b0;
    chk({name, " req_count1"}, n1, 32'(exp_req && hit1));
    chk({name, " req_count2"}, n2, 32'(exp_req && hit2));
    if (exp_req) begin
      chk({name, " req_latency"}, req_it, FD + 4);
      chk({name, " wrt"}, 32'(wrt_obs), 32'(do_wr));
      chk({name, " port"}, 32'(port_obs), hit1 ? 32'(addr % 4) : 32'(addr % 8));
      if (do_wr) chk({name, " dbo"}, 32'(dbo_obs), 32'(data));
      chk({name, " timeouts"}, nto, 32'(ack_dly == 0));
      if (ack_dly == 0) chk({name, " timeout_at"}, to_it, req_it + TO + 1);
    end else begin
      chk({name, " timeouts"}, nto, 0);
    end
    $display("txn %s addr=%02h rd=%0d wr=%0d m1_n=%0d len=%0d ack=%0d req=%0d/%0d to=%0d",
             name, addr, do_rd, do_wr, m1n, len, ack_dly, n1, n2, nto);
  endtask

  initial begin
    bit         found;
    logic [7:0] r_addr;
    int         sel;
    reset_n = 1'b0; CpuAck = 1'b0; tb_cd_oe = 1'b0; tb_cd = 8'h00; CpuDbi = 8'h00;
    rd_n = 1'b1; wr_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; A = 8'h98;

    // Reset state, with a read strobe on the pins to expose rd_data and WAIT.
    repeat (2) @(negedge clk);
    iorq_n = 1'b0; rd_n = 1'b0; #1;
    chk("rst CpuReq", 32'(req1), 0);
    chk("rst CpuWrt", 32'(wrt1), 0);
    chk("rst CpuPort", 32'(port1), 0);
    chk("rst CpuDbo", 32'(dbo1), 0);
    chk("rst CpuTimeout", 32'(to1), 0);
    chk("rst wait_n", 32'(wait1_n), 1);
    chk("rst cs_n", 32'(cs1_n), 0);
    chk("rst rd_data", 32'(cd), 32'hFF);
    rd_n = 1'b1; iorq_n = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);

    run_cycle("wr_port1", 1'b0, 1'b1, 1'b1, 8'h99, 8'h5A, 8'h00, 20, 3);
    run_cycle("rd_port3", 1'b1, 1'b0, 1'b1, 8'h9B, 8'h00, 8'hC3, 20, 2);
    run_cycle("glitch_wr", 1'b0, 1'b1, 1'b1, 8'h98, 8'h11, 8'h00, 2, 1);
    run_cycle("min_wr", 1'b0, 1'b1, 1'b1, 8'h9A, 8'h22, 8'h00, FD, 1);
    run_cycle("both_strb", 1'b1, 1'b1, 1'b1, 8'h98, 8'h00, 8'h00, 20, 1);
    run_cycle("inta", 1'b1, 1'b0, 1'b0, 8'h98, 8'h00, 8'h00, 20, 1);
    run_cycle("rd_timeout", 1'b1, 1'b0, 1'b1, 8'h98, 8'h00, 8'h3C, 30, 0);
    run_cycle("short_rd", 1'b1, 1'b0, 1'b1, 8'h9A, 8'h00, 8'h6E, 4, 5);
    run_cycle("sweep_8F", 1'b0, 1'b1, 1'b1, 8'h8F, 8'hA7, 8'h00, 12, 1);
    run_cycle("sweep_98", 1'b0, 1'b1, 1'b1, 8'h98, 8'h3D, 8'h00, 12, 1);

    // Reset asserted while waiting for acknowledge.
    A = 8'h99; tb_cd = 8'h77; tb_cd_oe = 1'b1; iorq_n = 1'b0; wr_n = 1'b0; m1_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (req1) found = 1'b1;
    end
    chk("midrst req_seen", 32'(found), 1);
    chk("midrst wait_low", 32'(wait1_n), 0);
    reset_n = 1'b0; #1;
    chk("midrst wait_n", 32'(wait1_n), 1);
    chk("midrst io_state", 32'(dut1.io_state_q), 32'(IDLE));
    iorq_n = 1'b1; wr_n = 1'b1; tb_cd_oe = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    run_cycle("post_rst_wr", 1'b0, 1'b1, 1'b1, 8'h99, 8'h81, 8'h00, 20, 2);

    for (int t = 0; t < 12; t++) begin
      r_addr = 8'($urandom_range(8'h86, 8'h9D));
      sel    = int'($urandom_range(0, 9));
      run_cycle("rnd", sel <= 4, sel >= 4, $urandom_range(0, 7) != 0, r_addr,
                8'($urandom), 8'($urandom), int'($urandom_range(1, 25)),
                int'($urandom_range(0, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
